mult_nxn_fast: RTL and testbench

MULT_NXN_FAST -- requirements
Module: mult_nxn_fast

---
 rtl/mult_nxn_fast.sv | 219 +++++++++++++++++++++
 tb/tb_mult_nxn_fast.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_nxn_fast.sv
`default_nettype none
// ============================================================================
// Module      : mult_nxn_fast
// Description : Iterative WIDTH x WIDTH multiplier built from one DIGIT x DIGIT
//               digit multiplier. Operands are reduced to magnitudes at start;
//               only digit pairs inside the significant digits of each
//               magnitude are visited, so small operands finish early. The
//               sign is reapplied when the result is written.
//
// Ports       : clk        - clock, all state updates on the rising edge
//               reset      - synchronous active-high reset
//               start      - request, sampled only while idle
//               a, b       - WIDTH-bit operands, sampled with start
//               is_signed  - 1: two's-complement operands, 0: unsigned
//               busy       - high from the edge after an accepted start
//                            until completion
//               done       - one-cycle completion pulse
//               product    - 2*WIDTH-bit result register
//
// Revision    : 1.0 - initial release
// ============================================================================
module mult_nxn_fast #(
    parameter int WIDTH = 32,   // must be a positive multiple of DIGIT
    parameter int DIGIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int          ND      = WIDTH / DIGIT;
    localparam int          IW      = (ND > 1) ? $clog2(ND) : 1;
    localparam int          PW      = 2 * WIDTH;
    localparam logic [31:0] C_DIGIT = 32'(DIGIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q,   state_d;
    logic [WIDTH-1:0]  a_mag_q,   a_mag_d;
    logic [WIDTH-1:0]  b_mag_q,   b_mag_d;
    logic              neg_q,     neg_d;
    logic [IW-1:0]     na_last_q, na_last_d;   // NA-1
    logic [IW-1:0]     nb_last_q, nb_last_d;   // NB-1
    logic [IW-1:0]     i_q,       i_d;         // outer digit index (a)
    logic [IW-1:0]     j_q,       j_d;         // inner digit index (b)
    logic [PW-1:0]     acc_q,     acc_d;
    logic [PW-1:0]     prod_q,    prod_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    // ------------------------------------------------------------------------
    // Operand magnitudes at start. Unary minus in WIDTH bits maps the most
    // negative value onto 2^(WIDTH-1), which is exactly representable
    // unsigned, so no extra bit is needed.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic [IW-1:0]     w_na_last;
    logic [IW-1:0]     w_nb_last;

    assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // Index of the highest nonzero digit; a zero magnitude leaves index 0,
    // which still schedules one (zero) partial product.
    logic [ND-1:0][DIGIT-1:0] w_a_start_dig;
    logic [ND-1:0][DIGIT-1:0] w_b_start_dig;

    assign w_a_start_dig = w_a_mag;
    assign w_b_start_dig = w_b_mag;

    always_comb begin
        w_na_last = '0;
        w_nb_last = '0;
        for (int k = 0; k < ND; k++) begin
            if (w_a_start_dig[k] != '0) begin
                w_na_last = IW'(k);
            end
            if (w_b_start_dig[k] != '0) begin
                w_nb_last = IW'(k);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Partial product datapath: one digit pair per CALC cycle, aligned to
    // (i+j)*DIGIT before accumulation.
    // ------------------------------------------------------------------------
    logic [ND-1:0][DIGIT-1:0] w_a_dig;
    logic [ND-1:0][DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0]         w_da;
    logic [DIGIT-1:0]         w_db;
    logic [2*DIGIT-1:0]       w_pp;
    logic [31:0]              w_shamt;
    logic [PW-1:0]            w_pp_sh;

    assign w_a_dig = a_mag_q;
    assign w_b_dig = b_mag_q;
    assign w_da    = w_a_dig[i_q];
    assign w_db    = w_b_dig[j_q];
    assign w_pp    = w_da * w_db;
    assign w_shamt = (32'(i_q) + 32'(j_q)) * C_DIGIT;
    assign w_pp_sh = PW'(w_pp) << w_shamt;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        na_last_d = na_last_q;
        nb_last_d = nb_last_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_mag_d   = w_a_mag;
                    b_mag_d   = w_b_mag;
                    neg_d     = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    na_last_d = w_na_last;
                    nb_last_d = w_nb_last;
                    i_d       = '0;
                    j_d       = '0;
                    acc_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CALC;
                end
            end

            S_CALC: begin
                acc_d = acc_q + w_pp_sh;
                // Indices never step past the significant digits, so
                // insignificant pairs cost no cycles.
                if (j_q == nb_last_q) begin
                    j_d = '0;
                    if (i_q == na_last_q) begin
                        state_d = S_FIN;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end

            S_FIN: begin
                prod_d  = neg_q ? -acc_q : acc_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            na_last_q <= '0;
            nb_last_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            prod_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            na_last_q <= na_last_d;
            nb_last_q <= nb_last_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_nxn_fast.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_nxn_fast
// Description : Scoreboard bench for mult_nxn_fast (WIDTH=32, DIGIT=16).
//               A driver issues requests and queues the expected product and
//               latency; a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_nxn_fast;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [63:0] product;

    mult_nxn_fast #(
        .WIDTH (32),
        .DIGIT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: plain integer arithmetic
    // ------------------------------------------------------------------------
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
        logic [63:0] ex, ey;
        ex = s ? {{32{x[31]}}, x} : {32'd0, x};
        ey = s ? {{32{y[31]}}, y} : {32'd0, y};
        return ex * ey;   // low 64 bits are exact for both interpretations
    endfunction

    // Number of base-2^16 digits needed for the magnitude (at least one)
    function automatic int ref_digits(input logic [31:0] v, input logic s);
        logic [31:0] m;
        m = (s && v[31]) ? (32'd0 - v) : v;
        return (m > 32'h0000_FFFF) ? 2 : 1;
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y, input logic s);
        return ref_digits(x, s) * ref_digits(y, s) + 1;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 65535));
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
            5:       return $urandom & 32'hFFFF_0000;
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    int          busy_cnt  = 0;
    logic [63:0] last_prod = 64'd0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset) begin
            busy_cnt  = 0;
            last_prod = 64'd0;
        end else begin
            if (busy) begin
                busy_cnt++;
                chk("product_hold", product, last_prod);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("product",   product,                    e.prod);
                    chk("latency",   64'(cyc - e.start_cyc),     64'(e.lat));
                    chk("busy_span", 64'(busy_cnt),              64'(e.lat));
                    last_prod = e.prod;
                end
                busy_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    // Called at a negedge; returns at the first negedge with busy low.
    // With noise set, operands and start are scrambled while busy.
    task automatic wait_idle(input bit noise, output bit ok);
        int guard = 0;
        ok = 1'b1;
        while (busy) begin
            if (noise) begin
                a         = $urandom;
                b         = $urandom;
                is_signed = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                n_chk++;
                n_err++;
                $display("FAIL idle_timeout: got busy=1 expected idle within 100 cycles");
                start = 1'b0;
                ok    = 1'b0;
                return;
            end
        end
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input logic [63:0] ep, input int el, input bit noise, input int gap);
        bit   ok;
        exp_t e;
        wait_idle(noise, ok);
        if (!ok) return;
        a           = ia;
        b           = ib;
        is_signed   = is;
        start       = 1'b1;
        e.prod      = ep;
        e.lat       = el;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic issue_ref(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                             input bit noise, input int gap);
        issue(ia, ib, is, ref_prod(ia, ib, is), ref_lat(ia, ib, is), noise, gap);
    endtask

    initial begin
        #950_000;
        $display("FAIL watchdog: got no finish expected finish before 95000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] ra, rb;
        logic        rs;
        int          guard;

        reset     = 1'b1;
        start     = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",    64'(busy), 64'd0);
        chk("reset_done",    64'(done), 64'd0);
        chk("reset_product", product,   64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-derived results and latencies
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 5, 1'b1, 0);
        issue(32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060, 2, 1'b1, 1);
        issue(32'h0001_0000, 32'h0000_0003, 1'b0, 64'h0000_0000_0003_0000, 3, 1'b0, 0);
        issue(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 2, 1'b0, 0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 5, 1'b1, 2);
        issue(32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000, 3, 1'b0, 0);
        issue(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_0000, 2, 1'b0, 0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 3, 1'b0, 0);

        // Abort a full-width multiply during its second CALC cycle
        wait_idle(1'b0, ok);
        a         = 32'hFFFF_FFFF;
        b         = 32'hFFFF_FFFF;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy",    64'(busy), 64'd0);
        chk("abort_done",    64'(done), 64'd0);
        chk("abort_product", product,   64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);

        // Recovery and back-to-back pair
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 5, 1'b0, 0);
        issue(32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060, 2, 1'b0, 0);
        issue(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 2, 1'b0, 0);

        // Randomized mix
        for (int n = 0; n < 10000; n++) begin
            ra = rand_op();
            rb = rand_op();
            rs = 1'($urandom_range(0, 1));
            issue_ref(ra, rb, rs, ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        // Drain
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0 || busy) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
